// File: rtl/posit_pkg.sv
// Shared posit constants and types used by the encoder, decoder and multiplier.
package posit_pkg;

    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 2;
    localparam int SCALE_W  = 7;

    function automatic int sat_bound(input int n, input int es);
        return (n - 2) << es;
    endfunction

    localparam int SAT_BOUND = sat_bound(POSIT_N, POSIT_ES);

    typedef enum logic [2:0] {
        K_NORM,
        K_ZERO,
        K_NAR,
        K_MAX,
        K_MIN
    } kind_t;

endpackage

// File: rtl/posit_round.sv
// Round-to-nearest-even on a posit magnitude, clamped to [minpos, maxpos].
module posit_round
    import posit_pkg::*;
#(
    parameter int N = POSIT_N
) (
    input  logic [N-2:0] mag,
    input  logic         guard,
    input  logic         sticky,
    output logic [N-2:0] rounded
);

    logic up;

    always_comb begin
        up      = guard && (sticky || mag[0]);
        rounded = mag;
        // Incrementing maxpos would spill into the NaR pattern.
        if (up && !(&mag)) begin
            rounded = mag + 1'b1;
        end
        if (rounded == '0) begin
            rounded = {{(N-2){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/posit_encode.sv
// Two-stage posit encoder: scale decode and saturation check, then
// pack, round and negate, with a valid/ready handshake on both sides.
module posit_encode
    import posit_pkg::*;
#(
    parameter int N  = POSIT_N,
    parameter int ES = POSIT_ES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [SCALE_W-1:0] in_scale,
    input  logic [N-4:0]       in_frac,
    input  logic               in_sticky,
    input  logic               in_zero,
    input  logic               in_nar,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_posit,
    output logic               out_sat
);

    localparam int BOUND = sat_bound(N, ES);
    localparam logic signed [SCALE_W-1:0] SAT_HI = SCALE_W'(BOUND);
    localparam logic signed [SCALE_W-1:0] SAT_LO = SCALE_W'(-BOUND);
    localparam int L = 2*N + ES - 1;

    typedef struct packed {
        kind_t              kind;
        logic               sign;
        logic               neg;
        logic [SCALE_W-1:0] shamt;
        logic [ES-1:0]      exp;
        logic [N-4:0]       frac;
        logic               sticky;
    } s1_t;

    s1_t s1_d;
    s1_t s1_q;
    logic s1_valid;
    logic load_in;
    logic load2;

    logic signed [SCALE_W-1:0] scale_s;
    logic signed [SCALE_W-1:0] k;

    assign scale_s = $signed(in_scale);
    assign k       = scale_s >>> ES;

    always_comb begin
        s1_d.sign   = in_sign;
        s1_d.neg    = k[SCALE_W-1];
        // Run of k+1 ones needs shift k; run of -k zeros needs shift -k-1.
        s1_d.shamt  = k[SCALE_W-1] ? ~k : k;
        s1_d.exp    = in_scale[ES-1:0];
        s1_d.frac   = in_frac;
        s1_d.sticky = in_sticky;
        if (in_nar) begin
            s1_d.kind = K_NAR;
        end else if (in_zero) begin
            s1_d.kind = K_ZERO;
        end else if (scale_s > SAT_HI) begin
            s1_d.kind = K_MAX;
        end else if (scale_s < SAT_LO) begin
            s1_d.kind = K_MIN;
        end else begin
            s1_d.kind = K_NORM;
        end
    end

    logic signed [L-1:0] seed;
    logic signed [L-1:0] packed_w;
    logic [N-2:0]        mag;
    logic                guard;
    logic                stick;
    logic [N-2:0]        rounded;
    logic [N-2:0]        mag_sel;
    logic [N-1:0]        word_d;
    logic                sat_d;

    always_comb begin
        seed     = {~s1_q.neg, s1_q.neg, s1_q.exp, s1_q.frac, {N{1'b0}}};
        packed_w = seed >>> s1_q.shamt;
        mag      = packed_w[L-1 -: N-1];
        guard    = packed_w[L-N];
        stick    = (|packed_w[L-N-1:0]) | s1_q.sticky;
    end

    posit_round #(.N(N)) u_round (
        .mag     (mag),
        .guard   (guard),
        .sticky  (stick),
        .rounded (rounded)
    );

    always_comb begin
        mag_sel = rounded;
        sat_d   = 1'b0;
        case (s1_q.kind)
            K_MAX: begin
                mag_sel = '1;
                sat_d   = 1'b1;
            end
            K_MIN: begin
                mag_sel = {{(N-2){1'b0}}, 1'b1};
                sat_d   = 1'b1;
            end
            default: ;
        endcase
        word_d = {1'b0, mag_sel};
        if (s1_q.sign) begin
            word_d = ~word_d + 1'b1;
        end
        if (s1_q.kind == K_ZERO) begin
            word_d = '0;
        end
        if (s1_q.kind == K_NAR) begin
            word_d = {1'b1, {(N-1){1'b0}}};
        end
    end

    assign load2    = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || load2;
    assign load_in  = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            out_valid <= 1'b0;
            out_posit <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (load_in) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_d;
            end else if (load2) begin
                s1_valid <= 1'b0;
            end
            if (load2) begin
                out_valid <= 1'b1;
                out_posit <= word_d;
                out_sat   <= sat_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
